// File: rtl/shift_pkg.sv
// Shared word/state types and ShiftRows helpers for the tx loader, the
// inverse-shift collector and the bench.
package shift_pkg;

  localparam int unsigned NUM_WORDS = 4;
  localparam int unsigned WORD_W    = 32;

  typedef logic [WORD_W-1:0]    word_t;
  typedef word_t [NUM_WORDS-1:0] state_t;
  typedef logic [1:0]           beat_t;

  // Forward ShiftRows: out[c] byte r = in[(c+r)%4] byte r (byte 0 is the MSB)
  function automatic state_t shift_rows(input state_t s);
    state_t o;
    beat_t  src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 2'(c + r);
        o[2'(c)][31-8*r -: 8] = s[src][31-8*r -: 8];
      end
    end
    return o;
  endfunction

  // Inverse ShiftRows: out[c] byte r = in[(c-r)%4] byte r
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    beat_t  src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 2'(c - r);
        o[2'(c)][31-8*r -: 8] = s[src][31-8*r -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/shift_rows_tx_if.sv
// Load/stream bundle between the ShiftRows transmitter and its environment.
// Optional word_parity appears when SHIFT_ROWS_TX_PARITY_EN is defined.
interface shift_rows_tx_if;
  import shift_pkg::*;

  logic   load;
  state_t state_in;
  logic   out_ready;
  word_t  word_out;
  logic   word_valid;
  logic   busy;
  logic   done;
  logic   abort;
`ifdef SHIFT_ROWS_TX_PARITY_EN
  logic   word_parity;
`endif

  // Transmitter side
  modport master (
    input  load, state_in, out_ready,
`ifdef SHIFT_ROWS_TX_PARITY_EN
    output word_parity,
`endif
    output word_out, word_valid, busy, done, abort
  );

  // Environment side: loads states and consumes words
  modport slave (
    output load, state_in, out_ready,
`ifdef SHIFT_ROWS_TX_PARITY_EN
    input  word_parity,
`endif
    input  word_out, word_valid, busy, done, abort
  );

endinterface

// File: rtl/shift_rows_tx.sv
// ShiftRows transmitter: captures a 4x32 state in one cycle, applies forward
// ShiftRows and streams the four columns out over valid/ready.
// TIMEOUT_CYC > 0 aborts a transfer after that many consecutive stalls.
// Define SHIFT_ROWS_TX_PARITY_EN to add an even-parity bit per word.
module shift_rows_tx
  import shift_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic          clk,
  input  logic          reset,
  shift_rows_tx_if.master tx
);

  localparam int unsigned STALL_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e             state_q, state_d;
  beat_t              cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  state_t             hold_q, hold_d;
  word_t              word_out_q, word_out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;

  state_t shifted;
  logic   xfer;
  beat_t  cnt_nxt;

  assign shifted = shift_rows(tx.state_in);
  assign xfer    = valid_q & tx.out_ready;
  assign cnt_nxt = cnt_q + 2'd1;

  // Next-state, beat/stall counters and output words
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_d    = stall_q;
    hold_d     = hold_q;
    word_out_d = word_out_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx.load) begin
          state_d    = SEND;
          hold_d     = shifted;
          word_out_d = shifted[0];
          valid_d    = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = '0;
          stall_d    = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          stall_d = '0;
          if (cnt_q == 2'd3) begin
            done_d = 1'b1;
            cnt_d  = '0;
            // A load on the last beat chains straight into the next state
            if (tx.load) begin
              hold_d     = shifted;
              word_out_d = shifted[0];
            end else begin
              state_d    = IDLE;
              word_out_d = '0;
              valid_d    = 1'b0;
              busy_d     = 1'b0;
            end
          end else begin
            cnt_d      = cnt_nxt;
            word_out_d = hold_q[cnt_nxt];
          end
        end else if (TIMEOUT_CYC != 0) begin
          if (stall_q == STALL_LAST) begin
            state_d    = IDLE;
            abort_d    = 1'b1;
            cnt_d      = '0;
            stall_d    = '0;
            word_out_d = '0;
            valid_d    = 1'b0;
            busy_d     = 1'b0;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stall_q    <= '0;
      hold_q     <= '0;
      word_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stall_q    <= stall_d;
      hold_q     <= hold_d;
      word_out_q <= word_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign tx.word_out   = word_out_q;
  assign tx.word_valid = valid_q;
  assign tx.busy       = busy_q;
  assign tx.done       = done_q;
  assign tx.abort      = abort_q;

`ifdef SHIFT_ROWS_TX_PARITY_EN
  logic parity_q, parity_d;

  // Even parity of the next word, forced low when nothing is valid
  always_comb begin
    parity_d = 1'b0;
    if (valid_d) parity_d = ^word_out_d;
  end

  // Parity register tracks word_out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end

  assign tx.word_parity = parity_q;
`endif

endmodule

// File: tb/tb_shift_rows_tx.sv
// Directed bench for shift_rows_tx: default instance (no timeout) and a
// TIMEOUT_CYC=5 instance. Parity checks follow SHIFT_ROWS_TX_PARITY_EN.
module tb_shift_rows_tx;
  import shift_pkg::*;

  logic clk;
  logic reset;

  shift_rows_tx_if if0 ();
  shift_rows_tx_if if1 ();

  shift_rows_tx #(.TIMEOUT_CYC(0)) u_dut (
    .clk  (clk),
    .reset(reset),
    .tx   (if0.master)
  );

  shift_rows_tx #(.TIMEOUT_CYC(5)) u_dut_to (
    .clk  (clk),
    .reset(reset),
    .tx   (if1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check word, valid, busy, done on the default instance
  task automatic chk_out(input string tag, input logic [31:0] w, input logic v,
                         input logic b, input logic d);
    chk({tag, ".word"},  if0.word_out, w);
    chk({tag, ".valid"}, 32'(if0.word_valid), 32'(v));
    chk({tag, ".busy"},  32'(if0.busy), 32'(b));
    chk({tag, ".done"},  32'(if0.done), 32'(d));
  endtask

  task automatic chk_par(input string tag, input logic p);
`ifdef SHIFT_ROWS_TX_PARITY_EN
    chk({tag, ".par"}, 32'(if0.word_parity), 32'(p));
`else
    if (p === 1'bx) $display("unused %s", tag);
`endif
  endtask

  state_t s1, s_a5, s_ff, s_odd;
  logic [31:0] exp_w [4];

  initial begin
    s1    = {32'h30313233, 32'h20212223, 32'h10111213, 32'h00010203};
    s_a5  = {4{32'hA5A5A5A5}};
    s_ff  = {32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC};
    s_odd = {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001};
    exp_w[0] = 32'h00112233;
    exp_w[1] = 32'h10213203;
    exp_w[2] = 32'h20310213;
    exp_w[3] = 32'h30011223;

    reset = 1'b0;
    if0.load = 1'b0; if0.state_in = '0; if0.out_ready = 1'b0;
    if1.load = 1'b0; if1.state_in = '0; if1.out_ready = 1'b0;
    step();
    chk_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.abort", 32'(if0.abort), 32'h0);
    chk_par("reset", 1'b0);
    reset = 1'b1;
    step();

    // 1. Basic send
    if0.load = 1'b1; if0.state_in = s1; if0.out_ready = 1'b1;
    step();
    if0.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("t1.b%0d", i), exp_w[i], 1'b1, 1'b1, 1'b0);
      chk_par($sformatf("t1.b%0d", i), 1'b0);
      step();
    end
    chk_out("t1.end", 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    chk("t1.done_clr", 32'(if0.done), 32'h0);

    // 2. Backpressure before beat 1
    if0.load = 1'b1; if0.state_in = s1; if0.out_ready = 1'b1;
    step();
    if0.load = 1'b0;
    chk_out("t2.b0", exp_w[0], 1'b1, 1'b1, 1'b0);
    step();
    if0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("t2.stall%0d", i), exp_w[1], 1'b1, 1'b1, 1'b0);
    end
    if0.out_ready = 1'b1;
    step();
    chk_out("t2.b2", exp_w[2], 1'b1, 1'b1, 1'b0);
    step();
    chk_out("t2.b3", exp_w[3], 1'b1, 1'b1, 1'b0);
    step();
    chk_out("t2.end", 32'h0, 1'b0, 1'b0, 1'b1);
    step();

    // 3. Back-to-back load on the 4th transfer
    if0.load = 1'b1; if0.state_in = s1;
    step();
    if0.load = 1'b0;
    step(); step(); step();
    chk_out("t3.b3", exp_w[3], 1'b1, 1'b1, 1'b0);
    if0.load = 1'b1; if0.state_in = s_a5;
    step();
    if0.load = 1'b0;
    chk_out("t3.next", 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_out($sformatf("t3.a5b%0d", i), 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0);
    end
    step();
    chk_out("t3.end", 32'h0, 1'b0, 1'b0, 1'b1);
    step();

    // 4. Load during beat 1 is ignored
    if0.load = 1'b1; if0.state_in = s1;
    step();
    if0.state_in = s_ff;
    chk_out("t4.b0", exp_w[0], 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      if0.load = 1'b0;
      chk_out($sformatf("t4.b%0d", i), exp_w[i], 1'b1, 1'b1, 1'b0);
    end
    step();
    chk_out("t4.end", 32'h0, 1'b0, 1'b0, 1'b1);
    step();

    // 5. Timeout on the TIMEOUT_CYC=5 instance; default instance never aborts
    if0.out_ready = 1'b0; if1.out_ready = 1'b0;
    if0.load = 1'b1; if0.state_in = s1;
    if1.load = 1'b1; if1.state_in = s1;
    step();
    if0.load = 1'b0; if1.load = 1'b0;
    chk("t5.first_valid", 32'(if1.word_valid), 32'h1);
    chk("t5.first_word", if1.word_out, exp_w[0]);
    for (int i = 1; i < 5; i++) begin
      step();
      chk($sformatf("t5.noabort%0d", i), 32'(if1.abort), 32'h0);
    end
    step();
    chk("t5.abort", 32'(if1.abort), 32'h1);
    chk("t5.valid", 32'(if1.word_valid), 32'h0);
    chk("t5.busy", 32'(if1.busy), 32'h0);
    chk("t5.done", 32'(if1.done), 32'h0);
    chk("t5.def_abort", 32'(if0.abort), 32'h0);
    chk_out("t5.def_hold", exp_w[0], 1'b1, 1'b1, 1'b0);
    step();
    chk("t5.abort_clr", 32'(if1.abort), 32'h0);
    chk("t5.done_after", 32'(if1.done), 32'h0);

    // 6. Async reset during beat 2
    if0.out_ready = 1'b1;
    step();
    chk_out("t6.b1", exp_w[1], 1'b1, 1'b1, 1'b0);
    step();
    chk_out("t6.b2", exp_w[2], 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_out("t6.async", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t6.abort", 32'(if0.abort), 32'h0);
    chk_par("t6.async", 1'b0);
    step();
    reset = 1'b1;
    step();
    chk_out("t6.idle", 32'h0, 1'b0, 1'b0, 1'b0);

    // Fresh load after reset, including an odd-parity column
    if0.load = 1'b1; if0.state_in = s_odd;
    step();
    if0.load = 1'b0;
    chk_out("t6.w0", 32'h00000000, 1'b1, 1'b1, 1'b0);
    chk_par("t6.w0", 1'b0);
    step();
    chk_out("t6.w1", 32'h00000001, 1'b1, 1'b1, 1'b0);
    chk_par("t6.w1", 1'b1);
    step(); step(); step();
    chk_out("t6.end", 32'h0, 1'b0, 1'b0, 1'b1);
    chk_par("t6.end", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
